// File: rtl/snn_pkg.sv
// snn_pkg: shared FSM state type and default parameters for the SNN controller.
// No ports. It provides state_t, DEF_IMG_BITS (pixels per image) and DEF_ASCII_ZERO
// (the offset that turns a result digit into a transmitted character).
package snn_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, WAIT, START, RUN, TX} state_t;
    localparam int DEF_IMG_BITS = 784;
    localparam logic [7:0] DEF_ASCII_ZERO = 8'h30;
endpackage

// File: rtl/snn_ctrl_if.sv
// snn_ctrl_if: bundles the UART, image-RAM, snn_core and result signals of snn_ctrl.
// UART rx:  rx_rdy, rx_data -> ctrl; clr_rx_rdy <- ctrl
// RAM:      ram_we, ram_addr, ram_d <- ctrl
// snn_core: snn_addr, snn_done, snn_digit -> ctrl; snn_start <- ctrl
// UART tx:  tx_done -> ctrl; tx_start, tx_data <- ctrl
// result:   digit <- ctrl
// Modports: master is the controller side and slave is the environment side.
interface snn_ctrl_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_d;
    logic [9:0] snn_addr;
    logic       snn_start;
    logic       snn_done;
    logic [3:0] snn_digit;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic [3:0] digit;
    modport master (
        input  rx_rdy, rx_data, snn_addr, snn_done, snn_digit, tx_done,
        output clr_rx_rdy, ram_we, ram_addr, ram_d, snn_start, tx_start, tx_data, digit
    );
    modport slave (
        output rx_rdy, rx_data, snn_addr, snn_done, snn_digit, tx_done,
        input  clr_rx_rdy, ram_we, ram_addr, ram_d, snn_start, tx_start, tx_data, digit
    );
endinterface

// File: rtl/img_loader.sv
// img_loader: turns received bytes into an LSB-first pixel stream with a running pixel address.
// Ports: clk, rst_n (async, active-low)
//        load    - capture byte_in and restart the 3-bit bit counter
//        shift   - one pixel is being written this cycle, so advance shift_reg, the counter and bit_addr
//        clr     - zero bit_addr
//        bit_addr, bit_out - current pixel address and pixel value
//        last    - this pixel ends the byte (8th bit or final image pixel)
//        full    - this pixel is the final pixel of the image
module img_loader
    import snn_pkg::*;
#(
    parameter int IMG_BITS = DEF_IMG_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic       clr,
    input  logic [7:0] byte_in,
    output logic [9:0] bit_addr,
    output logic       bit_out,
    output logic       last,
    output logic       full
);
    logic [7:0] shift_reg;
    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt       <= '0;
            bit_addr  <= '0;
        end else begin
            if (load) begin
                shift_reg <= byte_in;
                cnt       <= '0;
            end else if (shift) begin
                shift_reg <= shift_reg >> 1;
                cnt       <= cnt + 3'd1;
            end
            if (clr)
                bit_addr <= '0;
            else if (shift)
                bit_addr <= bit_addr + 10'd1;
        end
    end

    assign bit_out = shift_reg[0];
    assign full    = bit_addr == 10'(IMG_BITS - 1);
    // The final byte may hold fewer than 8 pixels, so reaching the image size also ends it.
    assign last    = full || cnt == 3'd7;
endmodule

// File: rtl/snn_ctrl.sv
// snn_ctrl: loads a 1-bit image from UART into RAM, runs snn_core and sends back the digit in ASCII.
// Ports: clk, rst_n (async, active-low), bus (snn_ctrl_if.master: UART rx/tx, image RAM,
//        snn_core handshake, held result digit).
// Parameters: IMG_BITS (pixels per image), ASCII_ZERO (offset added to the digit before sending).
module snn_ctrl
    import snn_pkg::*;
#(
    parameter int IMG_BITS = DEF_IMG_BITS,
    parameter logic [7:0] ASCII_ZERO = DEF_ASCII_ZERO
) (
    input logic        clk,
    input logic        rst_n,
    snn_ctrl_if.master bus
);
    state_t     state, nxt;
    logic       load, clr, last, full, bit_out;
    logic [9:0] bit_addr;

    // A byte is accepted only while loading an image. A byte that arrives in START, RUN or TX stays pending.
    assign load = (state == IDLE || state == WAIT) && bus.rx_rdy;
    assign clr  = state == IDLE || (state == TX && bus.tx_done);

    img_loader #(.IMG_BITS(IMG_BITS)) u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (state == WRITE),
        .clr      (clr),
        .byte_in  (bus.rx_data),
        .bit_addr (bit_addr),
        .bit_out  (bit_out),
        .last     (last),
        .full     (full)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.rx_rdy ? WRITE : IDLE;
            WRITE:   nxt = last ? (full ? START : WAIT) : WRITE;
            WAIT:    nxt = bus.rx_rdy ? WRITE : WAIT;
            START:   nxt = RUN;
            RUN:     nxt = bus.snn_done ? TX : RUN;
            TX:      nxt = bus.tx_done ? IDLE : TX;
            default: nxt = IDLE;
        endcase
    end

    assign bus.ram_addr = state == RUN ? bus.snn_addr : bit_addr;
    assign bus.ram_d    = bit_out;

    // The strobes are decoded from the next state, so each one comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.ram_we     <= 1'b0;
            bus.snn_start  <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.clr_rx_rdy <= 1'b0;
            bus.tx_data    <= '0;
            bus.digit      <= '0;
        end else begin
            state          <= nxt;
            bus.ram_we     <= nxt == WRITE;
            bus.snn_start  <= nxt == START;
            bus.tx_start   <= state == RUN && bus.snn_done;
            bus.clr_rx_rdy <= load;
            if (state == RUN && bus.snn_done) begin
                bus.digit   <= bus.snn_digit;
                bus.tx_data <= ASCII_ZERO + {4'b0, bus.snn_digit};
            end
        end
    end
endmodule

// File: tb/tb_snn_ctrl.sv
// tb_snn_ctrl: directed scoreboard bench for snn_ctrl (UART, RAM and snn_core modelled here).
module tb_snn_ctrl;
    import snn_pkg::*;

    localparam int N  = DEF_IMG_BITS;
    localparam int NB = (N + 7) / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    snn_ctrl_if bus();

    snn_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] a;
        logic       d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] txq[$];
    logic       ram_m[1024];
    int         wr_n[1024];
    int n_chk = 0, n_pass = 0;
    int clr_cnt = 0, start_cnt = 0, tx_cnt = 0, exp_addr = 0;
    logic pat_a5[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.clr_rx_rdy) clr_cnt++;
            if (bus.snn_start) start_cnt++;
            if (bus.ram_we) begin
                ram_m[bus.ram_addr] = bus.ram_d;
                wr_n[bus.ram_addr]++;
                chk("wr_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    chk("wr_addr", bus.ram_addr, wq[0].a);
                    chk("wr_bit", bus.ram_d, wq[0].d);
                    void'(wq.pop_front());
                end
            end
            if (bus.tx_start) begin
                tx_cnt++;
                chk("tx_expected", 32'(txq.size() > 0), 1);
                if (txq.size() > 0) chk("tx_data", bus.tx_data, txq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic post_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        for (int i = 0; i < 8; i++)
            if (exp_addr < N) begin
                wq.push_back('{a: 10'(exp_addr), d: b[i]});
                exp_addr++;
            end
    endtask

    task automatic await_ack(input string tag);
        int i = 0;
        while (!bus.clr_rx_rdy && i < 200) begin
            tick();
            i++;
        end
        chk(tag, bus.clr_rx_rdy, 1);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (wq.size() > 0 && i < 50) begin
            tick();
            i++;
        end
        chk("drain", wq.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        post_byte(b);
        await_ack("ack");
        drain();
    endtask

    task automatic reset_checks();
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_snn_start", bus.snn_start, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_clr_rx_rdy", bus.clr_rx_rdy, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_digit", bus.digit, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
    endtask

    task automatic run_core(input logic [3:0] d, input bit with_rx, input logic [7:0] rxb);
        int i = 0;
        int c0;
        while (!bus.snn_start && i < 50) begin
            tick();
            i++;
        end
        chk("snn_start", bus.snn_start, 1);
        exp_addr = 0;
        tick();
        chk("snn_start_pulse", bus.snn_start, 0);
        for (int k = 0; k < 4; k++) begin
            bus.snn_addr = 10'($urandom_range(0, 1023));
            #1;
            chk("run_ram_addr", bus.ram_addr, bus.snn_addr);
            chk("run_ram_we", bus.ram_we, 0);
            tick();
        end
        c0 = clr_cnt;
        if (with_rx) begin
            post_byte(rxb);
            tick(3);
            chk("no_ack_in_run", clr_cnt, c0);
        end
        bus.snn_digit = d;
        bus.snn_done  = 1'b1;
        txq.push_back(8'h30 + {4'h0, d});
        tick();
        bus.snn_done = 1'b0;
    endtask

    task automatic tx_phase(input logic [3:0] d, input int hold);
        int c0 = clr_cnt;
        chk("tx_start", bus.tx_start, 1);
        tick();
        chk("tx_start_pulse", bus.tx_start, 0);
        tick(hold);
        chk("digit_latched", bus.digit, d);
        chk("no_ack_in_tx", clr_cnt, c0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        chk("digit_held", bus.digit, d);
    endtask

    initial begin
        int s0, t0, c0;
        bus.rx_rdy    = 1'b0;
        bus.rx_data   = '0;
        bus.snn_addr  = '0;
        bus.snn_done  = 1'b0;
        bus.snn_digit = '0;
        bus.tx_done   = 1'b0;
        for (int i = 0; i < 1024; i++) wr_n[i] = 0;
        tick(3);
        reset_checks();
        rst_n = 1'b1;
        tick(2);

        // Image 1: all ones, then the core returns 7.
        for (int b = 0; b < NB; b++) send_byte(8'hFF);
        run_core(4'd7, 1'b0, 8'h00);
        tx_phase(4'd7, 3);
        chk("img1_tx_cnt", tx_cnt, 1);
        chk("img1_start_cnt", start_cnt, 1);
        for (int i = 0; i < N; i++) chk("ram_ones", ram_m[i], 1);
        chk("ram_784_untouched", wr_n[N], 0);

        // Image 2: A5 first, a byte arrives during RUN together with snn_done, and the digit is 12.
        c0 = clr_cnt;
        send_byte(8'hA5);
        chk("a5_ack_once", clr_cnt - c0, 1);
        for (int i = 0; i < 8; i++) chk("ram_a5", ram_m[i], pat_a5[i]);
        for (int b = 1; b < NB; b++) send_byte(8'h00);
        run_core(4'd12, 1'b1, 8'h3C);
        tx_phase(4'd12, 4);
        chk("img2_tx_cnt", tx_cnt, 2);
        await_ack("pending_ack");
        drain();
        chk("pending_bit0", ram_m[0], 0);
        chk("pending_bit2", ram_m[2], 1);

        // snn_done during WAIT must be ignored.
        tick();
        t0 = tx_cnt;
        bus.snn_digit = 4'd5;
        bus.snn_done  = 1'b1;
        tick();
        bus.snn_done = 1'b0;
        tick(3);
        chk("wait_no_tx", tx_cnt, t0);
        chk("wait_digit", bus.digit, 12);
        send_byte(8'h55);
        for (int b = 2; b < 50; b++) send_byte(8'(b));

        // Reset during a partial load, then load a full new image.
        rst_n = 1'b0;
        tick();
        reset_checks();
        rst_n    = 1'b1;
        exp_addr = 0;
        s0       = start_cnt;
        tick(2);
        for (int b = 0; b < NB - 1; b++) send_byte(8'($urandom_range(0, 255)));
        tick(3);
        chk("no_start_partial", start_cnt, s0);
        send_byte(8'hC3);
        run_core(4'd3, 1'b0, 8'h00);
        tx_phase(4'd3, 2);
        chk("img3_start_cnt", start_cnt, s0 + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
